// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MULTU/DIVU sequencer for the EX stage.
//
// The block runs one shift-add (MULTU) or restoring-division (DIVU)
// iteration per cycle through the shared combinational 32-bit ALU. After
// ITER iterations it presents the HI/LO pair in the DONE cycle.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   start        request pulse, sampled only in IDLE
//   op           0 = MULTU, 1 = DIVU (sampled with start)
//   a, b         multiplicand/dividend and multiplier/divisor (unsigned)
//   alu_in1/2    operands driven to the shared ALU
//   alu_cmd      ALU command (4'b0000 add, 4'b0010 subtract)
//   alu_result   combinational ALU result, valid in the same cycle
//   busy         high from the cycle after acceptance through DONE
//   done         one-cycle completion pulse; hi/lo valid in this cycle
//   hi, lo       MULTU product[63:32]/[31:0], or DIVU remainder/quotient
//   div_by_zero  set with done when DIVU had b == 0
module muldiv_seq #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [3:0]  alu_cmd,
    input  logic [31:0] alu_result,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    localparam logic [3:0] CMD_ADD  = 4'b0000;
    localparam logic [3:0] CMD_SUB  = 4'b0010;
    localparam logic [4:0] LAST_CNT = 5'(ITER - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;

    // acc_r is P_hi (MULTU) or R (DIVU); shf_r is P_lo or Q; opb_r is M or D.
    logic [31:0] acc_r;
    logic [31:0] shf_r;
    logic [31:0] opb_r;
    logic [4:0]  count_r;

    logic        busy_r;
    logic        done_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        dbz_r;

    logic [31:0] acc_nxt_s;
    logic [31:0] shf_nxt_s;
    logic [31:0] div_s_s;
    logic        last_s;
    logic        dbz_req_s;

    assign last_s    = (count_r == LAST_CNT);
    assign dbz_req_s = op && (b == 32'd0);
    assign div_s_s   = {acc_r[30:0], shf_r[31]};

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (!op) begin
                        state_nxt_s = ST_MUL;
                    end else if (dbz_req_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_DIV;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (last_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // ALU drive and per-iteration datapath update.
    always_comb begin
        alu_in1   = 32'd0;
        alu_in2   = 32'd0;
        alu_cmd   = CMD_ADD;
        acc_nxt_s = acc_r;
        shf_nxt_s = shf_r;
        case (state_r)
            ST_MUL: begin
                alu_in1 = acc_r;
                alu_in2 = shf_r[0] ? opb_r : 32'd0;
                alu_cmd = CMD_ADD;
                // The add wrapped iff the sum is below an addend; that carry
                // becomes bit 31 of the shifted partial product.
                acc_nxt_s = {(alu_result < acc_r), alu_result[31:1]};
                shf_nxt_s = {alu_result[0], shf_r[31:1]};
            end
            ST_DIV: begin
                alu_in1 = div_s_s;
                alu_in2 = opb_r;
                alu_cmd = CMD_SUB;
                // acc_r[31] is the bit shifted out of s: the 33-bit partial
                // remainder then certainly exceeds D, and the 32-bit
                // difference is still exact.
                if (acc_r[31] || (div_s_s >= opb_r)) begin
                    acc_nxt_s = alu_result;
                    shf_nxt_s = {shf_r[30:0], 1'b1};
                end else begin
                    acc_nxt_s = div_s_s;
                    shf_nxt_s = {shf_r[30:0], 1'b0};
                end
            end
            default: begin
                alu_in1   = 32'd0;
                alu_in2   = 32'd0;
                alu_cmd   = CMD_ADD;
                acc_nxt_s = acc_r;
                shf_nxt_s = shf_r;
            end
        endcase
    end

    // Operand latching, iteration registers, counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_r   <= 32'd0;
            shf_r   <= 32'd0;
            opb_r   <= 32'd0;
            count_r <= 5'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            hi_r    <= 32'd0;
            lo_r    <= 32'd0;
            dbz_r   <= 1'b0;
        end else begin
            busy_r <= (state_nxt_s != ST_IDLE);
            done_r <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        acc_r   <= 32'd0;
                        shf_r   <= a;
                        opb_r   <= b;
                        count_r <= 5'd0;
                        dbz_r   <= dbz_req_s;
                        // Divide by zero skips iterating: results load now
                        // so they are valid in the immediately following DONE.
                        if (dbz_req_s) begin
                            hi_r <= a;
                            lo_r <= 32'hFFFF_FFFF;
                        end
                    end
                end
                ST_MUL, ST_DIV: begin
                    acc_r   <= acc_nxt_s;
                    shf_r   <= shf_nxt_s;
                    count_r <= count_r + 5'd1;
                    if (last_s) begin
                        hi_r <= acc_nxt_s;
                        lo_r <= shf_nxt_s;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign hi          = hi_r;
    assign lo          = lo_r;
    assign div_by_zero = dbz_r;

endmodule
